main_control_fsm: RTL



---
 rtl/main_control_fsm_if.sv | 34 +++
 rtl/main_control_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm_if.sv
// Control bundle between the LEGv8 multicycle main controller and the datapath.
// master = controller side, slave = datapath side.
interface main_control_fsm_if #(
  parameter int CNT_W = 16
);
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             reg2loc;
  logic             ir_write;
  logic             pc_incr;
  logic             pc_branch;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, alu_src, reg2loc, ir_write, pc_incr, pc_branch,
           mem_read, mem_write, mem_to_reg, reg_write, illegal, state, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, alu_src, reg2loc, ir_write, pc_incr, pc_branch,
           mem_read, mem_write, mem_to_reg, reg_write, illegal, state, instr_count
  );
endinterface

// File: rtl/main_control_fsm.sv
// LEGv8 multicycle main control: decodes the opcode, sequences FETCH..WB,
// handles memory wait and illegal-opcode trap, counts retired instructions.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | load IR, PC <= PC+4
// DECODE | classify opcode; illegal -> TRAP or retire as NOP
// EXEC   | ALU operation; CBZ/B resolve branch and retire here
// MEM    | data memory access, held until mem_ready
// WB     | register file write, retire
// TRAP   | sticky illegal-opcode halt, left only by reset
// RST    | reset state, all outputs quiet
module main_control_fsm #(
  parameter int CNT_W           = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  main_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd6,
    S_RST    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_RTYPE = 3'd1,
    C_LDUR  = 3'd2,
    C_STUR  = 3'd3,
    C_CBZ   = 3'd4,
    C_B     = 3'd5,
    C_ILL   = 3'd6
  } class_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  state_t           state_q, state_d;
  class_t           class_q, dec_class;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  always_comb begin
    dec_class = C_ILL;
    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB ||
        bus.opcode == OP_AND || bus.opcode == OP_ORR)
      dec_class = C_RTYPE;
    else if (bus.opcode == OP_LDUR)
      dec_class = C_LDUR;
    else if (bus.opcode == OP_STUR)
      dec_class = C_STUR;
    else if (bus.opcode[10:3] == 8'b10110100)
      dec_class = C_CBZ;
    else if (bus.opcode[10:5] == 6'b000101)
      dec_class = C_B;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      class_q   <= C_NONE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        class_q <= dec_class;
      if (state_d == S_TRAP)
        illegal_q <= 1'b1;
      if (retire)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    bus.alu_op     = 2'b00;
    bus.alu_src    = 1'b0;
    bus.reg2loc    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_incr    = 1'b0;
    bus.pc_branch  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        bus.ir_write = 1'b1;
        bus.pc_incr  = 1'b1;
        state_d      = S_DECODE;
      end

      S_DECODE: begin
        if (dec_class != C_ILL) begin
          state_d = S_EXEC;
        end else if (TRAP_ON_ILLEGAL) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_EXEC: begin
        bus.reg2loc = (class_q == C_STUR) || (class_q == C_CBZ);
        case (class_q)
          C_RTYPE: begin
            bus.alu_op = 2'b10;
            state_d    = S_WB;
          end
          C_LDUR, C_STUR: begin
            bus.alu_src = 1'b1;
            state_d     = S_MEM;
          end
          C_CBZ: begin
            bus.alu_op    = 2'b01;
            bus.pc_branch = bus.zero;
            state_d       = S_FETCH;
            retire        = 1'b1;
          end
          C_B: begin
            bus.pc_branch = 1'b1;
            state_d       = S_FETCH;
            retire        = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        bus.alu_src   = 1'b1;
        bus.reg2loc   = (class_q == C_STUR);
        bus.mem_read  = (class_q == C_LDUR);
        bus.mem_write = (class_q == C_STUR);
        if (bus.mem_ready) begin
          if (class_q == C_LDUR) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = (class_q == C_STUR);
          end
        end
      end

      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (class_q == C_LDUR);
        bus.reg2loc    = (class_q == C_STUR) || (class_q == C_CBZ);
        state_d        = S_FETCH;
        retire         = 1'b1;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_RST;
    endcase
  end

  assign bus.illegal     = illegal_q;
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;

endmodule
